// File: rtl/tf_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tf_addr_gen
// Brief    : Radix-16 NTT/FFT twiddle-ROM address sequencer with valid/last
//            qualifier aligned to the ROM read latency.
// Revision : 1.0
// ============================================================================
module tf_addr_gen #(
  parameter int LOG_N   = 12,
  parameter int ROM_LAT = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic                                           en,
  output logic                                           busy,
  output logic                                           done,
  output logic [((LOG_N/4) > 1 ? $clog2(LOG_N/4) : 1)-1:0] stage,
  output logic                                           addr_valid,
  output logic [LOG_N-1:0]                               tf_addr0,
  output logic [LOG_N-1:0]                               tf_addr1,
  output logic [LOG_N-1:0]                               tf_addr2,
  output logic [LOG_N-1:0]                               tf_addr3,
  output logic [LOG_N-1:0]                               tf_addr4,
  output logic [LOG_N-1:0]                               tf_addr5,
  output logic [LOG_N-1:0]                               tf_addr6,
  output logic [LOG_N-1:0]                               tf_addr7,
  output logic [LOG_N-1:0]                               tf_addr8,
  output logic [LOG_N-1:0]                               tf_addr9,
  output logic [LOG_N-1:0]                               tf_addr10,
  output logic [LOG_N-1:0]                               tf_addr11,
  output logic [LOG_N-1:0]                               tf_addr12,
  output logic [LOG_N-1:0]                               tf_addr13,
  output logic [LOG_N-1:0]                               tf_addr14,
  output logic [LOG_N-1:0]                               tf_addr15,
  output logic                                           tf_valid,
  output logic                                           tf_last
);

  localparam int S  = LOG_N / 4;
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int GW = LOG_N - 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [GW-1:0]      g_q;
  logic [SW-1:0]      s_q;
  logic [SW-1:0]      stage_q;
  logic               busy_q;
  logic               done_q;
  logic               addr_valid_q;
  logic               last_q;
  logic [ROM_LAT-1:0] vpipe_q;
  logic [ROM_LAT-1:0] lpipe_q;
  logic [LOG_N-1:0]   addr_q [16];
  logic [LOG_N-1:0]   addr_d [16];
  logic [LOG_N-1:0]   step_d;
  logic               last_issue_d;

  // Bits shifted past LOG_N are the mod-N reduction of the group step.
  assign step_d       = LOG_N'(g_q) << (4 * s_q);
  assign last_issue_d = (s_q == SW'(S - 1)) && (g_q == '1);

  generate
    for (genvar k = 0; k < 16; k++) begin : g_lane
      assign addr_d[k] = step_d * LOG_N'(k);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      g_q          <= '0;
      s_q          <= '0;
      stage_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      last_q       <= 1'b0;
      vpipe_q      <= '0;
      lpipe_q      <= '0;
      for (int k = 0; k < 16; k++) addr_q[k] <= '0;
    end else begin
      addr_valid_q <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;

      // The qualifier pipe runs free so stalls propagate as bubbles.
      vpipe_q[0] <= addr_valid_q;
      lpipe_q[0] <= last_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        lpipe_q[i] <= lpipe_q[i-1];
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            g_q     <= '0;
            s_q     <= '0;
          end
        end
        RUN: begin
          if (en) begin
            addr_q       <= addr_d;
            addr_valid_q <= 1'b1;
            stage_q      <= s_q;
            last_q       <= last_issue_d;
            g_q          <= g_q + 1'b1;
            if (last_issue_d) begin
              s_q     <= '0;
              state_q <= FLUSH;
            end else if (g_q == '1) begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (lpipe_q[ROM_LAT-1]) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign stage      = stage_q;
  assign addr_valid = addr_valid_q;
  assign tf_valid   = vpipe_q[ROM_LAT-1];
  assign tf_last    = lpipe_q[ROM_LAT-1];
  assign tf_addr0   = addr_q[0];
  assign tf_addr1   = addr_q[1];
  assign tf_addr2   = addr_q[2];
  assign tf_addr3   = addr_q[3];
  assign tf_addr4   = addr_q[4];
  assign tf_addr5   = addr_q[5];
  assign tf_addr6   = addr_q[6];
  assign tf_addr7   = addr_q[7];
  assign tf_addr8   = addr_q[8];
  assign tf_addr9   = addr_q[9];
  assign tf_addr10  = addr_q[10];
  assign tf_addr11  = addr_q[11];
  assign tf_addr12  = addr_q[12];
  assign tf_addr13  = addr_q[13];
  assign tf_addr14  = addr_q[14];
  assign tf_addr15  = addr_q[15];

endmodule
`default_nettype wire
